weight_pattern_gen: RTL

Sequential inverse of the ones-counter (popcount) block. Given a requested weight k, it enumerates, in ascending numeric order, every WIDTH-bit word containing exactly k set bits. Words are emitted one per valid/ready handshake. The block drives exhaustive stimulus into popcount-style logic and produces fixed-weight codewords for downstream consumers.

---
 rtl/weight_pattern_gen_if.sv | 33 +++
 rtl/weight_pattern_gen.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/weight_pattern_gen_if.sv
// ============================================================================
// Module  : weight_pattern_gen_if
// Brief   : Start/result handshake bundle for the fixed-weight word generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface weight_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int KW    = 4
);
  logic             start;
  logic [KW-1:0]    k;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] pattern;
  logic             last;
  logic             done;
  logic             err;

  modport master (
    output start, k, out_ready,
    input  busy, out_valid, pattern, last, done, err
  );

  modport slave (
    input  start, k, out_ready,
    output busy, out_valid, pattern, last, done, err
  );
endinterface

`default_nettype wire

// File: rtl/weight_pattern_gen.sv
// ============================================================================
// Module  : weight_pattern_gen
// Brief   : Enumerates all WIDTH-bit words of popcount k in ascending order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_pattern_gen #(
  parameter int WIDTH = 8,
  parameter int KW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  weight_pattern_gen_if.slave  bus
);

  localparam logic [KW-1:0]    c_WIDTH_K = KW'(WIDTH);
  localparam logic [WIDTH-1:0] c_ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   c_ONE_X   = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pattern, w_pattern_nxt;
  logic [WIDTH-1:0] r_top, w_top_nxt;
  logic             r_last, w_last_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [WIDTH-1:0] w_low_mask;
  logic [WIDTH-1:0] w_top_mask;
  logic [WIDTH:0]   w_p, w_t, w_t1, w_next;
  logic [KW-1:0]    w_shift;

  function automatic logic [KW-1:0] f_ctz(input logic [WIDTH-1:0] v);
    f_ctz = c_WIDTH_K;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) f_ctz = KW'(i);
    end
  endfunction

  // k == WIDTH wraps the shift to zero, so the subtraction yields all ones.
  assign w_low_mask = (c_ONE_W << bus.k) - c_ONE_W;
  assign w_top_mask = w_low_mask << (c_WIDTH_K - bus.k);

  // Gosper's hack, one extra bit wide so t+1 never overflows.
  assign w_p     = {1'b0, r_pattern};
  assign w_t     = w_p | (w_p - c_ONE_X);
  assign w_t1    = w_t + c_ONE_X;
  assign w_shift = f_ctz(r_pattern) + KW'(1);
  assign w_next  = w_t1 | (((~w_t & w_t1) - c_ONE_X) >> w_shift);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pattern <= '0;
      r_top     <= '0;
      r_last    <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pattern <= w_pattern_nxt;
      r_top     <= w_top_nxt;
      r_last    <= w_last_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_top_nxt     = r_top;
    w_last_nxt    = r_last;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.k > c_WIDTH_K) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt   = S_EMIT;
            w_pattern_nxt = w_low_mask;
            w_top_nxt     = w_top_mask;
            w_last_nxt    = (w_low_mask == w_top_mask);
            w_valid_nxt   = 1'b1;
            w_busy_nxt    = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (r_last) begin
            w_state_nxt = S_FIN;
            w_valid_nxt = 1'b0;
            w_last_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_pattern_nxt = w_next[WIDTH-1:0];
            w_last_nxt    = (w_next == {1'b0, r_top});
          end
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_last_nxt  = 1'b0;
      end
    endcase
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.pattern   = r_pattern;
  assign bus.last      = r_last;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule

`default_nettype wire
